// File: rtl/sprite_animation_control.sv
// Sprite frame sequencer: steps a frame index offset through LOOP, ONESHOT or PINGPONG
// sequences on a programmable frame timer. Frame 0 is the idle pose.
module sprite_animation_control #(
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_DELAY = 30,
    parameter int IDX_W       = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_is_active,
    input  logic             i_restart,
    input  logic [1:0]       i_mode,
    output logic [IDX_W-1:0] o_idx_offset,
    output logic             o_frame_tick,
    output logic             o_done,
    output logic             o_busy
);
    localparam int CNT_W = (FRAME_DELAY > 0) ? $clog2(FRAME_DELAY + 1) : 1;
    localparam logic [CNT_W-1:0] C_DELAY = CNT_W'(FRAME_DELAY);
    localparam logic [IDX_W-1:0] C_LAST  = IDX_W'(NUM_FRAMES - 1);
    localparam logic [IDX_W-1:0] C_ONE   = IDX_W'(1);
    // With only one animating frame there is nothing to bounce between.
    localparam bit PP_AS_LOOP = (NUM_FRAMES == 2);

    localparam logic [1:0] MODE_LOOP     = 2'd0;
    localparam logic [1:0] MODE_ONESHOT  = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_counter;
    logic [IDX_W-1:0] r_idx;
    logic             r_dir_down;
    logic [1:0]       r_mode_q;
    logic             r_frame_tick;
    logic             r_done;
    logic             r_busy;

    logic w_boundary;
    logic w_at_last;
    logic w_at_first;

    assign w_boundary = (r_counter == C_DELAY);
    assign w_at_last  = (r_idx == C_LAST);
    assign w_at_first = (r_idx == C_ONE);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_counter    <= '0;
            r_idx        <= '0;
            r_dir_down   <= 1'b0;
            r_mode_q     <= MODE_LOOP;
            r_frame_tick <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_counter <= '0;
                    if (i_is_active || i_restart) begin
                        r_state    <= S_RUN;
                        r_idx      <= C_ONE;
                        r_dir_down <= 1'b0;
                        r_busy     <= 1'b1;
                        r_mode_q   <= (i_mode == 2'd3) ? MODE_LOOP : i_mode;
                    end
                end
                S_RUN: begin
                    if (i_restart) begin
                        r_idx      <= C_ONE;
                        r_counter  <= '0;
                        r_dir_down <= 1'b0;
                    end else if (!w_boundary) begin
                        r_counter <= r_counter + CNT_W'(1);
                    end else begin
                        r_counter <= '0;
                        if (r_mode_q == MODE_ONESHOT) begin
                            if (!w_at_last) begin
                                r_idx        <= r_idx + C_ONE;
                                r_frame_tick <= 1'b1;
                            end else begin
                                r_state <= S_HOLD;
                                r_done  <= 1'b1;
                            end
                        end else if (r_mode_q == MODE_PINGPONG && !PP_AS_LOOP) begin
                            if (!r_dir_down) begin
                                r_frame_tick <= 1'b1;
                                if (w_at_last) begin
                                    r_dir_down <= 1'b1;
                                    r_idx      <= r_idx - C_ONE;
                                end else begin
                                    r_idx <= r_idx + C_ONE;
                                end
                            end else if (!w_at_first) begin
                                r_idx        <= r_idx - C_ONE;
                                r_frame_tick <= 1'b1;
                            end else if (i_is_active) begin
                                r_dir_down   <= 1'b0;
                                r_idx        <= r_idx + C_ONE;
                                r_frame_tick <= 1'b1;
                            end else begin
                                r_state    <= S_IDLE;
                                r_idx      <= '0;
                                r_dir_down <= 1'b0;
                                r_busy     <= 1'b0;
                            end
                        end else begin
                            if (!w_at_last) begin
                                r_idx        <= r_idx + C_ONE;
                                r_frame_tick <= 1'b1;
                            end else if (i_is_active) begin
                                r_idx        <= C_ONE;
                                r_frame_tick <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_idx   <= '0;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    r_counter <= '0;
                    if (i_restart) begin
                        r_state    <= S_RUN;
                        r_idx      <= C_ONE;
                        r_dir_down <= 1'b0;
                    end else if (!i_is_active) begin
                        r_state <= S_IDLE;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_idx     <= '0;
                    r_counter <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign o_idx_offset = r_idx;
    assign o_frame_tick = r_frame_tick;
    assign o_done       = r_done;
    assign o_busy       = r_busy;
endmodule

// File: tb/tb_sprite_animation_control.sv
// Directed bench for sprite_animation_control: three instances cover the default
// LOOP timing, a zero-delay ONESHOT, and a five-frame zero-delay PINGPONG.
module tb_sprite_animation_control;
    logic clk = 1'b0;
    logic rst_n;

    logic       a_active, a_restart;
    logic [1:0] a_mode;
    logic [3:0] a_idx;
    logic       a_tick, a_done, a_busy;

    logic       b_active, b_restart;
    logic [1:0] b_mode;
    logic [3:0] b_idx;
    logic       b_tick, b_done, b_busy;

    logic       c_active, c_restart;
    logic [1:0] c_mode;
    logic [3:0] c_idx;
    logic       c_tick, c_done, c_busy;

    int checks   = 0;
    int failures = 0;
    int tick_cnt;
    int nonzero_cnt;

    always #5 clk = ~clk;

    sprite_animation_control #(.NUM_FRAMES(4), .FRAME_DELAY(30), .IDX_W(4)) u_a (
        .i_clk(clk), .i_reset(rst_n), .i_is_active(a_active), .i_restart(a_restart),
        .i_mode(a_mode), .o_idx_offset(a_idx), .o_frame_tick(a_tick), .o_done(a_done),
        .o_busy(a_busy));

    sprite_animation_control #(.NUM_FRAMES(4), .FRAME_DELAY(0), .IDX_W(4)) u_b (
        .i_clk(clk), .i_reset(rst_n), .i_is_active(b_active), .i_restart(b_restart),
        .i_mode(b_mode), .o_idx_offset(b_idx), .o_frame_tick(b_tick), .o_done(b_done),
        .o_busy(b_busy));

    sprite_animation_control #(.NUM_FRAMES(5), .FRAME_DELAY(0), .IDX_W(4)) u_c (
        .i_clk(clk), .i_reset(rst_n), .i_is_active(c_active), .i_restart(c_restart),
        .i_mode(c_mode), .o_idx_offset(c_idx), .o_frame_tick(c_tick), .o_done(c_done),
        .o_busy(c_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, counting frame ticks on instance a.
    task automatic adv_a(input int n);
        tick_cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (a_tick) tick_cnt++;
        end
    endtask

    initial begin
        logic [3:0] pp_seq [10];
        pp_seq = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd1, 4'd2, 4'd3, 4'd4, 4'd3};

        rst_n = 1'b0;
        a_active = 0; a_restart = 0; a_mode = 2'd0;
        b_active = 0; b_restart = 0; b_mode = 2'd0;
        c_active = 0; c_restart = 0; c_mode = 2'd0;

        // Reset and idle quiet period
        repeat (3) step();
        chk("reset_idx", a_idx, 0);
        chk("reset_busy", a_busy, 0);
        chk("reset_tick", a_tick, 0);
        chk("reset_done", a_done, 0);
        rst_n = 1'b1;
        tick_cnt = 0; nonzero_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (a_tick || b_tick || c_tick) tick_cnt++;
            if (a_idx != 0 || a_busy || b_busy || c_busy) nonzero_cnt++;
        end
        chk("idle_ticks", tick_cnt, 0);
        chk("idle_activity", nonzero_cnt, 0);
        $display("txn idle: 200 cycles quiet");

        // LOOP at default timing
        a_mode = 2'd0; a_active = 1'b1;
        step();
        chk("loop_start_idx", a_idx, 1);
        chk("loop_start_busy", a_busy, 1);
        chk("loop_start_tick", a_tick, 0);
        a_active = 1'b1;
        adv_a(30);
        chk("loop_f1_hold_ticks", tick_cnt, 0);
        chk("loop_f1_hold_idx", a_idx, 1);
        step();
        chk("loop_idx2", a_idx, 2);
        chk("loop_tick2", a_tick, 1);
        adv_a(30);
        chk("loop_f2_ticks", tick_cnt, 0);
        step();
        chk("loop_idx3", a_idx, 3);
        chk("loop_tick3", a_tick, 1);
        adv_a(30);
        step();
        chk("loop_wrap_idx", a_idx, 1);
        chk("loop_wrap_tick", a_tick, 1);
        $display("txn loop: 1,2,3,1 at 31-cycle spacing");

        // LOOP with is_active dropped on frame 2
        adv_a(30);
        step();
        chk("drop_idx2", a_idx, 2);
        a_active = 1'b0;
        adv_a(30);
        step();
        chk("drop_idx3", a_idx, 3);
        chk("drop_busy3", a_busy, 1);
        adv_a(30);
        chk("drop_hold3_idx", a_idx, 3);
        step();
        chk("drop_exit_idx", a_idx, 0);
        chk("drop_exit_busy", a_busy, 0);
        chk("drop_exit_tick", a_tick, 0);
        $display("txn loop_drop: 3 completes then idle");

        // ONESHOT with zero delay
        b_mode = 2'd1; b_active = 1'b1;
        step();
        chk("os_idx1", b_idx, 1);
        step();
        chk("os_idx2", b_idx, 2);
        chk("os_tick2", b_tick, 1);
        step();
        chk("os_idx3", b_idx, 3);
        chk("os_done_early", b_done, 0);
        step();
        chk("os_hold_idx", b_idx, 3);
        chk("os_done", b_done, 1);
        chk("os_hold_tick", b_tick, 0);
        step();
        chk("os_done_pulse", b_done, 0);
        chk("os_hold_busy", b_busy, 1);
        chk("os_hold_idx2", b_idx, 3);
        b_active = 1'b0;
        step();
        chk("os_exit_idx", b_idx, 0);
        chk("os_exit_busy", b_busy, 0);
        $display("txn oneshot: 1,2,3 hold done exit");

        // PINGPONG with five frames, zero delay
        c_mode = 2'd2; c_active = 1'b1;
        step();
        chk("pp_start", c_idx, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("pp_seq%0d", i), c_idx, pp_seq[i]);
            chk($sformatf("pp_tick%0d", i), c_tick, 1);
        end
        c_active = 1'b0;
        step();
        chk("pp_down2", c_idx, 2);
        step();
        chk("pp_down1", c_idx, 1);
        step();
        chk("pp_exit_idx", c_idx, 0);
        chk("pp_exit_busy", c_busy, 0);
        chk("pp_exit_tick", c_tick, 0);
        $display("txn pingpong: 1..4..1..4,3 then down to idle");

        // restart coincident with a boundary, then mid-run mode change ignored
        a_mode = 2'd0; a_active = 1'b1;
        step();
        chk("rs_start", a_idx, 1);
        adv_a(30);
        step();
        chk("rs_idx2", a_idx, 2);
        adv_a(30);
        a_restart = 1'b1;
        step();
        a_restart = 1'b0;
        chk("rs_idx", a_idx, 1);
        chk("rs_tick", a_tick, 0);
        chk("rs_busy", a_busy, 1);
        a_mode = 2'd1;
        adv_a(30);
        chk("rs_counter_cleared", tick_cnt, 0);
        step();
        chk("rs_next_idx", a_idx, 2);
        adv_a(30);
        step();
        chk("rs_idx3", a_idx, 3);
        adv_a(30);
        step();
        chk("mode_kept_wrap", a_idx, 1);
        chk("mode_kept_nodone", a_done, 0);
        $display("txn restart: boundary overridden, mode held as LOOP");

        // Reset mid-run
        adv_a(5);
        rst_n = 1'b0;
        step();
        chk("mrst_idx", a_idx, 0);
        chk("mrst_busy", a_busy, 0);
        chk("mrst_tick", a_tick, 0);
        rst_n = 1'b1;
        a_active = 1'b0;
        step();
        $display("txn midreset: outputs cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
